// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared DDR4 controller definitions: arbiter FSM states, fifo_wdata tag layout
// and a small modular-increment helper used by the round-robin logic.
package ddr_mc_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  localparam int ARB_N_REQ     = 4;
  localparam int ARB_DATA_W    = 64;
  localparam int ARB_MAX_BURST = 8;
  localparam int ARB_LOCK_TMO  = 16;

  // Downstream decoders find the source tag above the payload in fifo_wdata.
  localparam int TAG_LSB = ARB_DATA_W;

  // (a + b) mod n, valid for a < n and b < n; avoids a generic divider.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin picker: rotate the request vector by ptr, priority-encode the
// lowest set bit, then un-rotate to recover the requester index.
module rr_pick
  import ddr_mc_pkg::*;
#(
  parameter  int N_REQ = ARB_N_REQ,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] rot;
  logic [ID_W-1:0]  off;

  always_comb begin
    rot = '0;
    off = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      rot[k] = req[ID_W'(wrap_add(32'(ptr), k, N_REQ))];
    end
    // Descending scan so the smallest offset from ptr wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = ID_W'(k);
        any = 1'b1;
      end
    end
    idx = ID_W'(wrap_add(32'(ptr), 32'(off), N_REQ));
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter with burst lock for a shared command/data FIFO;
// each accepted beat is pushed as {gnt_id, payload}.
module fifo_wr_arbiter
  import ddr_mc_pkg::*;
#(
  parameter  int N_REQ     = ARB_N_REQ,
  parameter  int DATA_W    = ARB_DATA_W,
  parameter  int MAX_BURST = ARB_MAX_BURST,
  parameter  int LOCK_TMO  = ARB_LOCK_TMO,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    fifo_winc,
  output logic [ID_W+DATA_W-1:0]  fifo_wdata,
  input  logic                    fifo_wfull,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    busy,
  output logic                    burst_trunc
);

  localparam int BEAT_W = $clog2(MAX_BURST) + 1;
  localparam int TMO_W  = $clog2(LOCK_TMO) + 1;

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              trunc_q, trunc_d;

  logic              pick_any;
  logic [ID_W-1:0]   pick_idx;
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic              gnt_valid;
  logic              gnt_last;
  logic              xfer;

  for (genvar g = 0; g < N_REQ; g++) begin : g_data
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign gnt_valid   = req_valid[gnt_id_q];
  assign gnt_last    = req_last[gnt_id_q];
  assign gnt_id      = gnt_id_q;
  assign busy        = (state_q == ARB_LOCK);
  assign burst_trunc = trunc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_id_q   <= gnt_id_d;
      beat_cnt_q <= beat_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      trunc_q    <= trunc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_id_d   = gnt_id_q;
    beat_cnt_d = beat_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    trunc_d    = 1'b0;
    req_ready  = '0;
    fifo_winc  = 1'b0;
    fifo_wdata = '0;
    xfer       = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          gnt_id_d   = pick_idx;
          beat_cnt_d = '0;
          tmo_cnt_d  = '0;
          state_d    = ARB_LOCK;
        end
      end

      ARB_LOCK: begin
        req_ready[gnt_id_q] = ~fifo_wfull;
        xfer       = gnt_valid & ~fifo_wfull;
        fifo_winc  = xfer;
        fifo_wdata = {gnt_id_q, data_arr[gnt_id_q]};

        // A full FIFO with valid high stalls both counters; an idle requester ages the lock.
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          tmo_cnt_d  = '0;
          if (gnt_last || (beat_cnt_q == BEAT_W'(MAX_BURST - 1))) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = ID_W'(wrap_add(32'(gnt_id_q), 1, N_REQ));
            trunc_d  = ~gnt_last;
          end
        end else if (!gnt_valid) begin
          if (tmo_cnt_q == TMO_W'(LOCK_TMO - 1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = ID_W'(wrap_add(32'(gnt_id_q), 1, N_REQ));
            trunc_d  = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester queues drive beats, a per-tag
// scoreboard checks every FIFO write, logs check grant order and timing.
module tb_fifo_wr_arbiter;
  import ddr_mc_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   reqValid;
  logic [255:0] reqData;
  logic [3:0]   reqLast;
  logic [3:0]   reqReady;
  logic         fifoWinc;
  logic [65:0]  fifoWdata;
  logic         fifoWfull;
  logic [1:0]   gntId;
  logic         busy;
  logic         burstTrunc;

  beat_t       pendQ [4][$];
  logic [63:0] sbQ [4][$];
  int          winLog[$];
  int          winTime[$];
  int          truncLog[$];
  int          expLog[$];
  int          cycle = 0;
  int          seqNum = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ(4), .DATA_W(64), .MAX_BURST(8), .LOCK_TMO(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (reqValid),
    .req_data    (reqData),
    .req_last    (reqLast),
    .req_ready   (reqReady),
    .fifo_winc   (fifoWinc),
    .fifo_wdata  (fifoWdata),
    .fifo_wfull  (fifoWfull),
    .gnt_id      (gntId),
    .busy        (busy),
    .burst_trunc (burstTrunc)
  );

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each requester presents the head of its own queue.
  task automatic applyStimulus();
    for (int i = 0; i < 4; i++) begin
      if (pendQ[i].size() != 0) begin
        reqValid[i]          = 1'b1;
        reqData[i*64 +: 64] = pendQ[i][0].data;
        reqLast[i]           = pendQ[i][0].last;
      end else begin
        reqValid[i]          = 1'b0;
        reqData[i*64 +: 64] = '0;
        reqLast[i]           = 1'b0;
      end
    end
  endtask

  task automatic pushBeat(input int i, input logic last);
    logic [63:0] d;
    d = {16'hA5C3, 16'(i), 32'(seqNum)};
    seqNum++;
    pendQ[i].push_back('{data: d, last: last});
    sbQ[i].push_back(d);
  endtask

  function automatic bit anyPending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < 4; i++) if (pendQ[i].size() != 0) p = 1'b1;
    return p;
  endfunction

  task automatic stepCycle();
    logic [3:0] acc;
    int         tag;
    #1;
    acc = reqValid & reqReady;
    if (fifoWinc) begin
      tag = int'(fifoWdata[TAG_LSB +: 2]);
      checkOutput("winc_while_full", 128'(fifoWfull), 128'(0));
      checkOutput("sb_has_entry", 128'(sbQ[tag].size() != 0), 128'(1));
      if (sbQ[tag].size() != 0)
        checkOutput("payload", 128'(fifoWdata[63:0]), 128'(sbQ[tag].pop_front()));
      winLog.push_back(tag);
      winTime.push_back(cycle);
    end
    if (burstTrunc) truncLog.push_back(cycle);
    @(posedge clk);
    cycle++;
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (acc[i]) void'(pendQ[i].pop_front());
    applyStimulus();
  endtask

  task automatic waitDrain(input string tag, input int limit);
    int k;
    k = 0;
    while ((anyPending() || busy) && k < limit) begin
      stepCycle();
      k++;
    end
    checkOutput(tag, 128'(k < limit), 128'(1));
  endtask

  task automatic stepUntilWins(input string tag, input int n, input int limit);
    int k;
    k = 0;
    while (winLog.size() < n && k < limit) begin
      stepCycle();
      k++;
    end
    checkOutput(tag, 128'(winLog.size()), 128'(n));
  endtask

  task automatic checkLog(input string tag);
    checkOutput({tag, "_len"}, 128'(winLog.size()), 128'(expLog.size()));
    for (int i = 0; i < winLog.size() && i < expLog.size(); i++)
      checkOutput({tag, "_order"}, 128'(winLog[i]), 128'(expLog[i]));
  endtask

  task automatic clearLogs();
    winLog.delete();
    winTime.delete();
    truncLog.delete();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    rst       = 1'b1;
    fifoWfull = 1'b0;
    reqValid  = '0;
    reqData   = '0;
    reqLast   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_ready", 128'(reqReady), 128'(0));
    checkOutput("rst_winc", 128'(fifoWinc), 128'(0));
    checkOutput("rst_wdata", 128'(fifoWdata), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_trunc", 128'(burstTrunc), 128'(0));
    checkOutput("rst_gnt", 128'(gntId), 128'(0));
    checkOutput("rst_ptr", 128'(dut.rr_ptr_q), 128'(0));
    rst = 1'b0;

    $display("[TB] single requester burst");
    clearLogs();
    pushBeat(1, 1'b0); pushBeat(1, 1'b0); pushBeat(1, 1'b1);
    applyStimulus();
    #1;
    checkOutput("t1_idle_winc", 128'(fifoWinc), 128'(0));
    checkOutput("t1_idle_busy", 128'(busy), 128'(0));
    stepCycle();
    #1;
    checkOutput("t1_busy", 128'(busy), 128'(1));
    checkOutput("t1_gnt", 128'(gntId), 128'(1));
    checkOutput("t1_ready", 128'(reqReady), 128'(4'b0010));
    waitDrain("t1_drain", 50);
    expLog = '{1, 1, 1};
    checkLog("t1");
    checkOutput("t1_ptr", 128'(dut.rr_ptr_q), 128'(2));
    checkOutput("t1_gnt_hold", 128'(gntId), 128'(1));
    checkOutput("t1_trunc", 128'(truncLog.size()), 128'(0));

    $display("[TB] fairness");
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    clearLogs();
    pushBeat(0, 1'b1); pushBeat(0, 1'b1);
    pushBeat(1, 1'b1); pushBeat(2, 1'b1); pushBeat(3, 1'b1);
    applyStimulus();
    waitDrain("t2_drain", 60);
    expLog = '{0, 1, 2, 3, 0};
    checkLog("t2");
    for (int i = 1; i < winTime.size(); i++)
      checkOutput("t2_spacing", 128'(winTime[i] - winTime[i-1]), 128'(2));

    $display("[TB] max burst release");
    clearLogs();
    for (int b = 0; b < 10; b++) pushBeat(2, b == 9);
    pushBeat(3, 1'b1);
    pushBeat(0, 1'b1);
    applyStimulus();
    waitDrain("t3_drain", 100);
    expLog = '{2, 2, 2, 2, 2, 2, 2, 2, 3, 0, 2, 2};
    checkLog("t3");
    checkOutput("t3_trunc_cnt", 128'(truncLog.size()), 128'(1));
    if (truncLog.size() == 1 && winTime.size() > 8) begin
      checkOutput("t3_trunc_time", 128'(truncLog[0]), 128'(winTime[7] + 1));
      checkOutput("t3_regrant_time", 128'(winTime[8]), 128'(winTime[7] + 2));
    end

    $display("[TB] fifo full stall");
    clearLogs();
    for (int b = 0; b < 6; b++) pushBeat(1, b == 5);
    applyStimulus();
    stepUntilWins("t4_first3", 3, 50);
    fifoWfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("t4_winc", 128'(fifoWinc), 128'(0));
      checkOutput("t4_ready", 128'(reqReady), 128'(0));
      checkOutput("t4_busy", 128'(busy), 128'(1));
      checkOutput("t4_beat_cnt", 128'(dut.beat_cnt_q), 128'(3));
      checkOutput("t4_tmo_cnt", 128'(dut.tmo_cnt_q), 128'(0));
      stepCycle();
    end
    fifoWfull = 1'b0;
    waitDrain("t4_drain", 50);
    expLog = '{1, 1, 1, 1, 1, 1};
    checkLog("t4");

    $display("[TB] lock timeout");
    clearLogs();
    pushBeat(2, 1'b0);
    pushBeat(3, 1'b1);
    applyStimulus();
    waitDrain("t5_drain", 80);
    expLog = '{2, 3};
    checkLog("t5");
    checkOutput("t5_trunc_cnt", 128'(truncLog.size()), 128'(1));
    if (truncLog.size() == 1 && winTime.size() == 2) begin
      checkOutput("t5_trunc_time", 128'(truncLog[0]), 128'(winTime[0] + 17));
      checkOutput("t5_next_grant", 128'(winTime[1]), 128'(winTime[0] + 18));
    end
    checkOutput("t5_gnt", 128'(gntId), 128'(3));

    $display("[TB] reset mid-burst");
    clearLogs();
    for (int b = 0; b < 8; b++) pushBeat(1, b == 7);
    applyStimulus();
    stepUntilWins("t6_first4", 4, 50);
    checkOutput("t6_beat_cnt", 128'(dut.beat_cnt_q), 128'(4));
    rst = 1'b1;
    stepCycle();
    rst = 1'b0;
    #1;
    checkOutput("t6_ready", 128'(reqReady), 128'(0));
    checkOutput("t6_winc", 128'(fifoWinc), 128'(0));
    checkOutput("t6_wdata", 128'(fifoWdata), 128'(0));
    checkOutput("t6_busy", 128'(busy), 128'(0));
    checkOutput("t6_trunc", 128'(burstTrunc), 128'(0));
    checkOutput("t6_gnt", 128'(gntId), 128'(0));
    checkOutput("t6_ptr", 128'(dut.rr_ptr_q), 128'(0));
    checkOutput("t6_state", 128'(dut.state_q), 128'(ARB_IDLE));
    waitDrain("t6_drain", 60);
    expLog = '{1, 1, 1, 1, 1, 1, 1, 1};
    checkLog("t6");
    checkOutput("t6_trunc_cnt", 128'(truncLog.size()), 128'(0));

    for (int i = 0; i < 4; i++)
      checkOutput("sb_empty", 128'(sbQ[i].size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
